x7seg_bcd_scan: RTL and testbench

Parametrised successor to the fixed 8-bit, 3-digit display driver. It converts an IN_W-bit unsigned binary value to DIGITS packed BCD digits using a sequential shift-and-add-3 (double dabble) engine with a start/busy/done handshake. It holds the last result and time-multiplexes it onto a common-anode 7-segment display with DIGITS active-low digit enables. It sits between any binary status/result register and the board's 7-segment pins.

---
 rtl/x7seg_bcd_scan.sv | 222 ++++++++++++++++++++++
 tb/tb_x7seg_bcd_scan.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x7seg_bcd_scan.sv
// -----------------------------------------------------------------------------
// x7seg_bcd_scan
// Converts an IN_W-bit unsigned value into DIGITS packed BCD digits with a
// sequential shift-and-add-3 (double dabble) engine behind a start/busy/done
// handshake. The last result is held and time-multiplexed onto a common-anode
// 7-segment display. Segment and digit-enable outputs are active low.
//
// Optional feature: define X7SEG_LZB_EN to blank leading zeros on the
// display. Digit 0 is never blanked, and the overflow dash takes priority.
// Handshake, bcd and timing are the same with or without the macro.
// -----------------------------------------------------------------------------
module x7seg_bcd_scan #(
  parameter int unsigned IN_W         = 8,
  parameter int unsigned DIGITS       = 3,
  parameter int unsigned REFRESH_LOG2 = 18
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic [IN_W-1:0]       x,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [6:0]            a_to_g,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(IN_W + 1);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef X7SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;

  // Conversion engine
  logic [IN_W-1:0]    sr_q, sr_d;        // binary bits still to be shifted in
  logic [BCD_W-1:0]   work_q, work_d;    // BCD working field
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   adj;               // working field after the add-3 step

  // Handshake and held result
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  // Display scan
  logic [REFRESH_LOG2-1:0] refresh_q, refresh_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  // Display decode temporaries
  logic [3:0]         digit_sel;
  logic               zero_above;
  logic               blank_sel;

  // Active-low common-anode glyphs, bit6=a ... bit0=g
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

  // State register; reset mid-conversion aborts straight back to idle
  // NOTE: every flop uses <= so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> SHIFT (IN_W cycles) -> DONE (1 cycle) -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic per state: load, add-3 and shift, then latch result
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sr_d     = sr_q;
    work_d   = work_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ovf_d    = ovf_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    // Correct every digit that would exceed 9 after doubling
    adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sr_d     = x;
          work_d   = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(IN_W);
          busy_d   = 1'b1;
        end
      end
      ST_SHIFT: begin
        // A set top bit here is shifted out: the value no longer fits
        {work_d, sr_d} = {adj[BCD_W-2:0], sr_q, 1'b0};
        sticky_d       = sticky_q | adj[BCD_W-1];
        cnt_d          = cnt_q - CNT_W'(1);
        busy_d         = 1'b1;
      end
      ST_DONE: begin
        bcd_d  = work_q;
        ovf_d  = sticky_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Free-running refresh counter; the scan index advances on each wrap
  always_comb begin
    refresh_d = refresh_q + REFRESH_LOG2'(1);
    idx_d     = idx_q;
    if (&refresh_q) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Datapath, handshake and scan registers
  // NOTE: all state here is small flops, so every register is reset; nothing is a RAM.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sr_q      <= '0;
      work_q    <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      refresh_q <= '0;
      idx_q     <= '0;
    end else begin
      sr_q      <= sr_d;
      work_q    <= work_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
    end
  end

  // Select the scanned digit, enable its anode and drive its glyph
  always_comb begin
    digit_sel  = 4'd0;
    zero_above = 1'b1;
    blank_sel  = 1'b0;
    an         = '1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (bcd_q[4*k +: 4] == 4'd0);
      if (idx_q == IDX_W'(k)) begin
        digit_sel = bcd_q[4*k +: 4];
        blank_sel = zero_above && (k != 0);
        an[k]     = 1'b0;
      end
    end

    if (ovf_q) begin
      a_to_g = SEG_DASH;
    end else if (LZB && blank_sel) begin
      a_to_g = SEG_BLANK;
    end else begin
      a_to_g = glyph(digit_sel);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_x7seg_bcd_scan.sv
// -----------------------------------------------------------------------------
// Testbench for x7seg_bcd_scan. Two instances share clock, reset and stimulus:
// dut_a (IN_W=8, DIGITS=3) and dut_b (IN_W=8, DIGITS=2, reachable overflow),
// both with REFRESH_LOG2=2. A behavioural model derives expected outputs from
// the conversion latency, decimal arithmetic and the scan period, and is
// compared against both instances on every falling edge. Directed sections
// pin the model with hand-computed literals; a random section follows.
// -----------------------------------------------------------------------------
module tb_x7seg_bcd_scan;

  localparam int IN_W = 8;
  localparam int RL   = 2;

`ifdef X7SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        clr_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  x     = 8'd0;

  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic [6:0]  a_to_g_a;
  logic [2:0]  an_a;

  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;
  logic [6:0]  a_to_g_b;
  logic [1:0]  an_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  x7seg_bcd_scan #(.IN_W(IN_W), .DIGITS(3), .REFRESH_LOG2(RL)) dut_a (
    .clk(clk), .clr_n(clr_n), .x(x), .start(start),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd(bcd_a),
    .a_to_g(a_to_g_a), .an(an_a)
  );

  x7seg_bcd_scan #(.IN_W(IN_W), .DIGITS(2), .REFRESH_LOG2(RL)) dut_b (
    .clk(clk), .clr_n(clr_n), .x(x), .start(start),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd(bcd_b),
    .a_to_g(a_to_g_b), .an(an_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] glyph_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

  function automatic int pow10(input int nd);
    int r = 1;
    for (int i = 0; i < nd; i++) r = r * 10;
    return r;
  endfunction

  // Decimal digits of v, truncated to nd digits (value mod 10^nd)
  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    int t = v;
    for (int i = 0; i < nd; i++) begin
      r = r | (32'(t % 10) << (4 * i));
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [31:0] b, input bit o, input int idx);
    int d;
    if (o) return 7'b1111110;
    if (LZB && idx > 0 && (b >> (4 * idx)) == 0) return 7'b1111111;
    d = int'((b >> (4 * idx)) & 32'hF);
    if (d > 9) return 7'b1111111;
    return glyph_tab[d];
  endfunction

  int          age;     // -1 when idle, else edges since the accepting edge
  logic [7:0]  xcap;
  int          ncyc;    // edges since reset release
  bit          m_busy, m_done, m_ovf_a, m_ovf_b;
  logic [31:0] m_bcd_a, m_bcd_b;

  // Conversion takes IN_W+1 edges after the accept edge; result appears with done
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      age <= -1; xcap <= '0; ncyc <= 0;
      m_busy <= 1'b0; m_done <= 1'b0;
      m_bcd_a <= '0; m_bcd_b <= '0; m_ovf_a <= 1'b0; m_ovf_b <= 1'b0;
    end else begin
      ncyc <= ncyc + 1;
      if (age < 0) begin
        m_done <= 1'b0;
        if (start) begin
          age    <= 0;
          xcap   <= x;
          m_busy <= 1'b1;
        end
      end else if (age == IN_W) begin
        age     <= -1;
        m_busy  <= 1'b0;
        m_done  <= 1'b1;
        m_bcd_a <= to_bcd(int'(xcap), 3);
        m_ovf_a <= int'(xcap) >= pow10(3);
        m_bcd_b <= to_bcd(int'(xcap), 2);
        m_ovf_b <= int'(xcap) >= pow10(2);
      end else begin
        age <= age + 1;
      end
    end
  end

  int         ia, ib;
  logic [2:0] ea;
  logic [1:0] eb;

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    ia = (ncyc >> RL) % 3;
    ib = (ncyc >> RL) % 2;
    ea = ~(3'b001 << ia);
    eb = ~(2'b01 << ib);
    check("busy_a", busy_a, m_busy);
    check("done_a", done_a, m_done);
    check("ovf_a",  ovf_a,  m_ovf_a);
    check("bcd_a",  bcd_a,  m_bcd_a);
    check("an_a",   an_a,   ea);
    check("seg_a",  a_to_g_a, exp_seg(m_bcd_a, m_ovf_a, ia));
    check("busy_b", busy_b, m_busy);
    check("done_b", done_b, m_done);
    check("ovf_b",  ovf_b,  m_ovf_b);
    check("bcd_b",  bcd_b,  m_bcd_b);
    check("an_b",   an_b,   eb);
    check("seg_b",  a_to_g_b, exp_seg(m_bcd_b, m_ovf_b, ib));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (done_a !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (done_a !== 1'b1) check({name, "_timeout"}, done_a, 1'b1);
  endtask

  task automatic convert(input logic [7:0] v, input string name);
    int n;
    x = v; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(name, n);
    tick();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, busy_cnt, m, ndone;
    logic [2:0] seen3;
    logic [1:0] seen2;

    // Reset state
    #1 clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_bcd",  bcd_a, 12'h000);
    check("rst_an",   an_a, 3'b110);
    check("rst_seg",  a_to_g_a, 7'b0000001);
    check("rst_an_b", an_b, 2'b10);
    clr_n = 1'b1;
    tick();

    // x=255: latency and busy length
    x = 8'd255; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0; n = 0;
    while (done_a !== 1'b1 && n < 50) begin
      if (busy_a === 1'b1) busy_cnt++;
      tick();
      n++;
    end
    check("lat255_cycle", n + 1, 10);  // done in the 10th cycle after the accept edge
    check("busy255_len", busy_cnt, 9);
    check("bcd255",  bcd_a, 12'h255);
    check("ovf255",  ovf_a, 1'b0);
    check("bcd255_b", bcd_b, 8'h55);
    check("ovf255_b", ovf_b, 1'b1);
    tick();

    // Back-to-back 0 then 109
    x = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("d0", n);
    check("bcd0", bcd_a, 12'h000);
    tick();
    x = 8'd109; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("d109", n);
    check("bcd109", bcd_a, 12'h109);
    seen3 = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      case (an_a)
        3'b110:  begin check("seg109_d0", a_to_g_a, 7'b0000100); seen3[0] = 1'b1; end
        3'b101:  begin check("seg109_d1", a_to_g_a, 7'b0000001); seen3[1] = 1'b1; end
        3'b011:  begin check("seg109_d2", a_to_g_a, 7'b1001111); seen3[2] = 1'b1; end
        default: check("an109_onehot", an_a, 3'b110);
      endcase
    end
    check("scan109_all", seen3, 3'b111);

    // Overflow on the 2-digit instance, then a fitting value
    convert(8'd100, "d100");
    check("ovf100_b", ovf_b, 1'b1);
    seen2 = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("dash100_b", a_to_g_b, 7'b1111110);
      if (an_b == 2'b10) seen2[0] = 1'b1;
      if (an_b == 2'b01) seen2[1] = 1'b1;
    end
    check("scan100_b", seen2, 2'b11);
    convert(8'd99, "d99");
    check("ovf99_b", ovf_b, 1'b0);
    check("bcd99_b", bcd_b, 8'h99);
    check("bcd99",   bcd_a, 12'h099);

    // Start held high, x changed mid-conversion
    x = 8'd200; start = 1'b1;
    tick();
    x = 8'd7;
    wait_done("held1", n);
    check("held_first", bcd_a, 12'h200);
    tick();
    m = 1;
    while (done_a !== 1'b1 && m < 50) begin
      tick();
      m++;
    end
    start = 1'b0;
    check("held_gap", m, IN_W + 2);
    check("held_second", bcd_a, 12'h007);
    tick();

    // Reset during the 4th SHIFT cycle
    x = 8'd123; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #1 clr_n = 1'b0;
    #1;
    check("abort_busy", busy_a, 1'b0);
    check("abort_done", done_a, 1'b0);
    check("abort_bcd",  bcd_a, 12'h000);
    check("abort_an",   an_a, 3'b110);
    check("abort_seg",  a_to_g_a, 7'b0000001);
    #1 clr_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done_a === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);

    // Leading zeros with x=7
    convert(8'd7, "d7");
    for (int i = 0; i < 12; i++) begin
      tick();
      if (an_a == 3'b110) check("seg7_d0", a_to_g_a, 7'b0001111);
      else check("seg7_lead", a_to_g_a, LZB ? 7'b1111111 : 7'b0000001);
    end

    // Random stimulus, checked by the model every cycle
    ndone = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      start = ($urandom_range(0, 3) == 0);
      x = 8'($urandom);
      if (done_a === 1'b1) ndone++;
      if ($urandom_range(0, 299) == 0) begin
        #1 clr_n = 1'b0;
        #1 clr_n = 1'b1;
      end
    end
    start = 1'b0;
    check("random_progress", ndone > 20, 1'b1);
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
